// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- UART transmitter. Frames are sent LSB first: start bit, 8 data
// bits, optional parity bit, 1 or 2 stop bits. The line idles high.
// A one-entry holding buffer lets a producer queue the next byte while the
// current frame is on the wire. Back-to-back frames have no idle gap.
//
// Ports
//   Clk      in   system clock, all logic on posedge
//   Reset    in   synchronous, active-high reset
//   TxData   in   [7:0] byte to send, sampled only on an accepting edge
//   TxStart  in   request strobe; accepted when TxStart && TxReady
//   TxReady  out  holding buffer empty, a byte can be accepted
//   TxWire   out  registered serial line, idle high
//   TxBusy   out  a frame is being shifted (state != IDLE)
//   TxDone   out  one-cycle pulse after the final stop bit period ends
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int CLOCK_FREQUENCY = 1_000_000,
    parameter int BAUD_RATE       = 9600,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] TxData,
    input  logic       TxStart,
    output logic       TxReady,
    output logic       TxWire,
    output logic       TxBusy,
    output logic       TxDone
);

    localparam int DIV   = (CLOCK_FREQUENCY + BAUD_RATE / 2) / BAUD_RATE;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(DIV - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx: CLOCK_FREQUENCY / BAUD_RATE must round to at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Parity bit sent on the wire for a given byte.
    function automatic logic parity_bit(input logic [7:0] b);
        return (PARITY == 1) ? ~(^b) : (^b);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [7:0]       buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;

    logic accept;
    logic bit_end;
    logic load_direct;
    logic load_buf;
    logic [7:0] load_byte;

    assign accept  = TxStart && !buf_full_q;
    assign bit_end = (baud_cnt_q == LAST_TICK);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        done_d      = 1'b0;
        load_direct = 1'b0;
        load_buf    = 1'b0;
        load_byte   = TxData;

        // Counter free-runs within a bit and wraps at the bit boundary.
        baud_cnt_d = (state_q == S_IDLE || bit_end) ? '0 : baud_cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (accept) load_direct = 1'b1;
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        // A queued byte wins; otherwise a byte offered on this
                        // very edge goes straight to the shifter.
                        if (buf_full_q)  load_buf    = 1'b1;
                        else if (accept) load_direct = 1'b1;
                        else             state_d     = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_direct || load_buf) begin
            load_byte  = load_buf ? buf_q : TxData;
            shift_d    = load_byte;
            par_d      = parity_bit(load_byte);
            state_d    = S_START;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
        end

        if (load_buf) buf_full_d = 1'b0;

        // Any accepted byte not taken directly by the shifter is buffered.
        if (accept && !load_direct) begin
            buf_d      = TxData;
            buf_full_d = 1'b1;
        end
    end

    // Line level follows the next state so TxWire is a pure register.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            buf_full_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            buf_full_q <= buf_full_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    // Data registers carry no reset; their contents are qualified by state.
    always_ff @(posedge Clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
        buf_q   <= buf_d;
    end

    assign TxReady = !buf_full_q;
    assign TxWire  = tx_q;
    assign TxBusy  = (state_q != S_IDLE);
    assign TxDone  = done_q;

endmodule
